cp0_regfile: RTL

CP0_REGFILE -- requirements
Module: cp0_regfile

---
 rtl/cp0_regfile_pkg.sv | 34 +++
 rtl/cp0_timer.sv | 74 +++++++
 rtl/cp0_regfile.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cp0_regfile_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cp0_regfile_pkg                                    |
// | Description : Shared CP0 constants: register numbers, exception  |
// |               codes and Status/Cause field bit positions.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package cp0_regfile_pkg;

  // CP0 register numbers (MFC0/MTC0 rd field)
  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_count    = 5'd9;
  localparam logic [4:0] c_reg_compare  = 5'd11;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;

  // Cause.ExcCode values
  localparam logic [4:0] c_exc_int  = 5'h00;
  localparam logic [4:0] c_exc_adel = 5'h04;
  localparam logic [4:0] c_exc_ades = 5'h05;
  localparam logic [4:0] c_exc_sys  = 5'h08;
  localparam logic [4:0] c_exc_bp   = 5'h09;
  localparam logic [4:0] c_exc_ri   = 5'h0A;
  localparam logic [4:0] c_exc_ov   = 5'h0C;

  // Status field positions
  localparam int c_st_ie    = 0;
  localparam int c_st_exl   = 1;
  localparam int c_st_im_lo = 8;
  localparam int c_st_im_hi = 15;

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cp0_timer                                          |
// | Description : CP0 Count/Compare timer. Count advances on every   |
// |               second clock; timer_int_o is sticky until Compare  |
// |               is rewritten.                                      |
// | Ports       : clk, resetn          - clock, async active-low rst |
// |               count_we, compare_we - MTC0 strobes                |
// |               wdata_i              - MTC0 data                   |
// |               count_o, compare_o   - register contents           |
// |               timer_int_o          - timer interrupt pending     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cp0_timer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        tint_q, tint_d;

  always_comb begin
    // Tick phase free-runs; a software Count write does not realign it.
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    tint_d    = tint_q;

    if (count_we) begin
      count_d = wdata_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end

    if (compare_we) begin
      compare_d = wdata_i;
    end

    // Clearing through a Compare write dominates a same-cycle match.
    if (compare_we) begin
      tint_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      tint_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      tint_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cp0_regfile                                        |
// | Description : MIPS CP0 subset: BadVAddr, Count, Compare, Status, |
// |               Cause, EPC with exception/ERET redirect logic.     |
// | Ports       : clk, resetn        - clock, async active-low reset |
// |               int_i              - hardware interrupt levels     |
// |               we_i/waddr_i/wdata_i - MTC0 write port             |
// |               raddr_i/rdata_o    - MFC0 read port (no bypass)    |
// |               pc_i, badaddr_i, in_delayslot_i - mem-stage context|
// |               *_i exception flags, eret_i                        |
// |               flush_o/newpc_o    - zero-latency redirect         |
// |               epc_o/status_o/cause_o/timer_int_o - state view    |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] badaddr_i,
  input  logic        in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        adel_d_i,
  input  logic        ades_i,
  input  logic        eret_i,
  output logic [31:0] rdata_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;

  logic        w_irq, w_exc_taken, w_eret_taken, w_wr_en;
  logic        w_bad_load, w_bad_sel_pc;
  logic [4:0]  w_exc_code;
  logic [31:0] w_count, w_compare, w_cause;

  assign w_cause = {bd_q, 15'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  assign w_irq = status_q[c_st_ie] & ~status_q[c_st_exl] &
                 (|({ip_hw_q, ip_sw_q} & status_q[c_st_im_hi:c_st_im_lo]));

  // Priority encoder over pending events; the first hit wins.
  always_comb begin
    w_exc_taken  = 1'b1;
    w_exc_code   = c_exc_int;
    w_bad_load   = 1'b0;
    w_bad_sel_pc = 1'b0;
    if (w_irq) begin
      w_exc_code = c_exc_int;
    end else if (adel_if_i) begin
      w_exc_code   = c_exc_adel;
      w_bad_load   = 1'b1;
      w_bad_sel_pc = 1'b1;
    end else if (ri_i) begin
      w_exc_code = c_exc_ri;
    end else if (ov_i) begin
      w_exc_code = c_exc_ov;
    end else if (syscall_i) begin
      w_exc_code = c_exc_sys;
    end else if (break_i) begin
      w_exc_code = c_exc_bp;
    end else if (adel_d_i) begin
      w_exc_code = c_exc_adel;
      w_bad_load = 1'b1;
    end else if (ades_i) begin
      w_exc_code = c_exc_ades;
      w_bad_load = 1'b1;
    end else begin
      w_exc_taken = 1'b0;
    end
  end

  assign w_eret_taken = eret_i & ~w_exc_taken;
  // An instruction being flushed must not commit its MTC0.
  assign w_wr_en      = we_i & ~w_exc_taken & ~w_eret_taken;
  assign flush_o      = resetn & (w_exc_taken | w_eret_taken);
  assign newpc_o      = w_exc_taken ? EXC_VECTOR : epc_q;

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    ip_hw_d    = {int_i[5] | timer_int_o, int_i[4:0]};

    if (w_wr_en) begin
      case (waddr_i)
        c_reg_status: begin
          status_d[c_st_im_hi:c_st_im_lo] = wdata_i[c_st_im_hi:c_st_im_lo];
          status_d[c_st_exl]              = wdata_i[c_st_exl];
          status_d[c_st_ie]               = wdata_i[c_st_ie];
        end
        c_reg_cause: ip_sw_d = wdata_i[9:8];
        c_reg_epc:   epc_d   = wdata_i;
        default: ;
      endcase
    end

    if (w_exc_taken) begin
      exccode_d          = w_exc_code;
      status_d[c_st_exl] = 1'b1;
      // Nested exceptions keep the original return point.
      if (!status_q[c_st_exl]) begin
        epc_d = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        bd_d  = in_delayslot_i;
      end
      if (w_bad_load) begin
        badvaddr_d = w_bad_sel_pc ? pc_i : badaddr_i;
      end
    end else if (w_eret_taken) begin
      status_d[c_st_exl] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= STATUS_RST;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      bd_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exccode_q  <= 5'd0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (w_wr_en && (waddr_i == c_reg_count)),
    .compare_we (w_wr_en && (waddr_i == c_reg_compare)),
    .wdata_i    (wdata_i),
    .count_o    (w_count),
    .compare_o  (w_compare),
    .timer_int_o(timer_int_o)
  );

  always_comb begin
    case (raddr_i)
      c_reg_badvaddr: rdata_o = badvaddr_q;
      c_reg_count:    rdata_o = w_count;
      c_reg_compare:  rdata_o = w_compare;
      c_reg_status:   rdata_o = status_q;
      c_reg_cause:    rdata_o = w_cause;
      c_reg_epc:      rdata_o = epc_q;
      default:        rdata_o = 32'd0;
    endcase
  end

  assign epc_o    = epc_q;
  assign status_o = status_q;
  assign cause_o  = w_cause;

endmodule
`default_nettype wire
